// File: rtl/bus_arbiter.sv
// Round-robin arbiter driving one requester's byte onto the shared register-bank bus
// and pulsing the matching register load strobe. Optional burst locking via `ARB_LOCK_EN.
module bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int NDST      = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 8,
    localparam int DW       = (NDST > 1) ? $clog2(NDST) : 1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   dst,
    input  logic [NREQ*W-1:0]    data,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]      lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic [W-1:0]         bus,
    output logic [NDST-1:0]      load,
    output logic                 busy,
    output logic                 err
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   pick;
    logic            any_req;
    int              idx;
    logic [PW-1:0]   sel;
    logic [DW-1:0]   sel_dst;
    logic [W-1:0]    sel_data;
    logic            sel_bad;
    logic [NDST-1:0] sel_load;
    logic [NREQ-1:0] sel_gnt;
    logic            extend;

    // Scan downward from the farthest slot so the nearest set bit at or after ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        pick    = ptr;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                pick    = PW'(idx);
                any_req = 1'b1;
            end
        end
    end

    // In IDLE the candidate is the fresh winner; in XFER it is the held owner (burst resample).
    always_comb begin
        sel      = (state == IDLE) ? pick : win;
        sel_dst  = dst[int'(sel)*DW +: DW];
        sel_data = data[int'(sel)*W +: W];
        sel_bad  = int'(sel_dst) >= NDST;
        sel_load = '0;
        for (int i = 0; i < NDST; i++) sel_load[i] = (int'(sel_dst) == i);
        sel_gnt  = '0;
        for (int i = 0; i < NREQ; i++) sel_gnt[i] = (int'(sel) == i);
    end

`ifdef ARB_LOCK_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] count;
    assign extend = lock[win] && req[win] && (int'(count) < MAX_BURST - 1);
`else
    assign extend = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state <= IDLE;
            gnt   <= '0;
            bus   <= '0;
            load  <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
            ptr   <= '0;
            win   <= '0;
`ifdef ARB_LOCK_EN
            count <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win   <= pick;
                        gnt   <= sel_gnt;
                        bus   <= sel_data;
                        load  <= sel_load;
                        err   <= sel_bad;
                        busy  <= 1'b1;
                        state <= XFER;
`ifdef ARB_LOCK_EN
                        count <= '0;
`endif
                    end else begin
                        gnt  <= '0;
                        bus  <= '0;
                        load <= '0;
                        err  <= 1'b0;
                        busy <= 1'b0;
                    end
                end
                XFER: begin
                    if (extend) begin
                        bus  <= sel_data;
                        load <= sel_load;
                        err  <= sel_bad;
`ifdef ARB_LOCK_EN
                        count <= count + 1'b1;
`endif
                    end else begin
                        gnt   <= '0;
                        bus   <= '0;
                        load  <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                        ptr   <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                        state <= IDLE;
`ifdef ARB_LOCK_EN
                        count <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a behavioural round-robin model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bus_arbiter;

    localparam int NREQ      = 4;
    localparam int NDST      = 3;
    localparam int W         = 8;
    localparam int MAX_BURST = 4;
    localparam int DW        = 2;

    logic                 clk = 1'b0;
    logic                 clr_n = 1'b0;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   dst;
    logic [NREQ*W-1:0]    data;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]      lock;
`endif
    logic [NREQ-1:0]      gnt;
    logic [W-1:0]         bus;
    logic [NDST-1:0]      load;
    logic                 busy;
    logic                 err;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter #(.NREQ(NREQ), .NDST(NDST), .W(W), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .req   (req),
        .dst   (dst),
        .data  (data),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .bus   (bus),
        .load  (load),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Register bank fed by the arbiter, as the real destination registers would be.
    logic [W-1:0] rq [NDST] = '{default: '0};
    always @(posedge clk) begin
        for (int i = 0; i < NDST; i++) if (load[i]) rq[i] <= bus;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: who owns the bus, where the rotation pointer sits, how many extra beats.
    int              owner;
    int              mptr;
    int              beats;
    logic [NREQ-1:0] exp_gnt;
    logic [NDST-1:0] exp_load;
    logic [W-1:0]    exp_bus;
    logic            exp_busy;
    logic            exp_err;

    function automatic int find_winner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task model_idle_outputs();
        exp_gnt = '0; exp_load = '0; exp_bus = '0; exp_busy = 1'b0; exp_err = 1'b0;
    endtask

    task model_reset();
        owner = -1; mptr = 0; beats = 0;
        model_idle_outputs();
    endtask

    task model_issue(input int w);
        int d;
        d = int'(dst[w*DW +: DW]);
        exp_gnt = '0;
        exp_gnt[w] = 1'b1;
        exp_bus = data[w*W +: W];
        exp_load = '0;
        exp_err = (d >= NDST);
        if (d < NDST) exp_load[d] = 1'b1;
        exp_busy = 1'b1;
    endtask

    task model_step();
        int  w;
        bit  more;
        if (owner < 0) begin
            w = find_winner(req, mptr);
            if (w >= 0) begin
                owner = w; beats = 0;
                model_issue(w);
            end else begin
                model_idle_outputs();
            end
        end else begin
            more = 1'b0;
`ifdef ARB_LOCK_EN
            more = lock[owner] && req[owner] && (beats < MAX_BURST - 1);
`endif
            if (more) begin
                beats++;
                model_issue(owner);
            end else begin
                mptr = (owner + 1) % NREQ;
                owner = -1;
                model_idle_outputs();
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!clr_n) model_reset(); else model_step();
            @(negedge clk);
            if (!clr_n) model_reset();
            check("gnt", 32'(gnt), 32'(exp_gnt));
            check("load", 32'(load), 32'(exp_load));
            check("busy", 32'(busy), 32'(exp_busy));
            check("err", 32'(err), 32'(exp_err));
            if (exp_gnt != '0) check("bus", 32'(bus), 32'(exp_bus));
        end
    end

    task automatic set_slot(input int i, input logic [DW-1:0] d, input logic [W-1:0] v);
        dst[i*DW +: DW] = d;
        data[i*W +: W]  = v;
    endtask

    logic [NREQ-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        req = '0; dst = '0; data = '0;
`ifdef ARB_LOCK_EN
        lock = '0;
`endif
        repeat (2) @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_bus", 32'(bus), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        #1 clr_n = 1'b1;

        // Single request into register 2.
        @(negedge clk); #1;
        set_slot(0, 2'd2, 8'hAA); req = 4'b0001;
        @(negedge clk);
        check("single_gnt", 32'(gnt), 32'h1);
        check("single_load", 32'(load), 32'h4);
        check("single_bus", 32'(bus), 32'hAA);
        #1 req = '0;
        @(negedge clk);
        check("single_reg2", 32'(rq[2]), 32'hAA);
        check("single_release", 32'(gnt), 32'h0);

        // Reset while a transfer is in flight: nothing may be loaded.
        #1 set_slot(0, 2'd2, 8'h55); req = 4'b0001;
        @(negedge clk);
        check("midx_load", 32'(load), 32'h4);
        #1 clr_n = 1'b0; req = '0;
        #1;
        check("midx_gnt", 32'(gnt), 32'h0);
        check("midx_load_clr", 32'(load), 32'h0);
        check("midx_bus", 32'(bus), 32'h0);
        @(negedge clk);
        check("midx_reg2", 32'(rq[2]), 32'hAA);
        #1 clr_n = 1'b1;

        // Continuous requests from everyone rotate one grant per two clocks.
        for (int i = 0; i < NREQ; i++) set_slot(i, DW'(i % NDST), 8'(8'h10 + i));
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check($sformatf("rr_gnt%0d", t), 32'(gnt), 32'(rr_seq[t]));
            @(negedge clk);
            check($sformatf("rr_gap%0d", t), 32'(gnt), 32'h0);
        end

        // Out-of-range destination: grant issued, no load, err pulse, pointer advances.
        #1 req = 4'b0010; set_slot(1, 2'd3, 8'h77);
        @(negedge clk);
        check("bad_gnt", 32'(gnt), 32'h2);
        check("bad_load", 32'(load), 32'h0);
        check("bad_err", 32'(err), 32'h1);
        #1 req = '0;
        @(negedge clk);
        check("bad_err_end", 32'(err), 32'h0);
        #1 req = 4'b0011; set_slot(0, 2'd1, 8'h33);
        @(negedge clk);
        check("bad_ptr_adv", 32'(gnt), 32'h1);
        check("bad_next_load", 32'(load), 32'h2);
        #1 req = '0;
        @(negedge clk);

        // Withdrawn request never reaches an arbitration edge.
        #1 req = 4'b0010;
        #2 req = '0;
        @(negedge clk);
        check("wd_gnt", 32'(gnt), 32'h0);
        check("wd_load", 32'(load), 32'h0);
        #1 req = 4'b1111;
        @(negedge clk);
        check("wd_ptr_kept", 32'(gnt), 32'h2);
        #1 req = '0;
        @(negedge clk);

`ifdef ARB_LOCK_EN
        // Locked burst: MAX_BURST back-to-back loads, then requester 1 gets its turn.
        #1 set_slot(0, 2'd0, 8'h01); set_slot(1, 2'd2, 8'hB1);
        req = 4'b0011; lock = 4'b0001;
        for (int b = 0; b < MAX_BURST; b++) begin
            @(negedge clk);
            check($sformatf("burst_gnt%0d", b), 32'(gnt), 32'h1);
            check($sformatf("burst_load%0d", b), 32'(load), 32'h1);
            check($sformatf("burst_bus%0d", b), 32'(bus), 32'(b + 1));
            #1 data[0 +: W] = 8'(b + 2);
        end
        @(negedge clk);
        check("burst_release", 32'(gnt), 32'h0);
        @(negedge clk);
        check("burst_next", 32'(gnt), 32'h2);
        #1 req = '0; lock = '0;
        @(negedge clk);
`endif

        // Randomized traffic against the model, with one asynchronous reset mid-run.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk); #1;
            req  = NREQ'($urandom);
            dst  = (NREQ*DW)'($urandom);
            data = $urandom;
`ifdef ARB_LOCK_EN
            lock = NREQ'($urandom);
`endif
            if (c == 400) clr_n = 1'b0;
            if (c == 402) clr_n = 1'b1;
        end
        @(negedge clk); #1 req = '0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
